// File: rtl/ntt_layer_ctrl.sv
// Layer sequencer for the 8-butterfly NTT/iNTT datapath: walks 7 layers,
// issues bank reads, computes twiddle base indices and delays write-backs.
module ntt_layer_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BU_LAT     = 4,
  parameter int unsigned N_RD       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            len_o,
  output logic [2:0]            layer_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
  output logic [6:0]            tw_idx_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_a_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_b_o
);

  localparam int unsigned L        = RD_LAT + BU_LAT;
  localparam int unsigned K_W      = $clog2(N_RD);
  localparam int unsigned D_W      = $clog2(L) + 1;
  localparam int unsigned N_LAYERS = 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [D_W-1:0] dcnt_q, dcnt_d;
  logic [2:0]     layer_q, layer_d;
  logic           mode_q, mode_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            layer_o_q, layer_o_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_WIDTH-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [6:0]            tw_idx_q, tw_idx_d;

  logic [L-1:0]          wr_en_pipe_q, wr_en_pipe_d;
  logic [ADDR_WIDTH-1:0] wr_a_pipe_q [L];
  logic [ADDR_WIDTH-1:0] wr_a_pipe_d [L];
  logic [ADDR_WIDTH-1:0] wr_b_pipe_q [L];
  logic [ADDR_WIDTH-1:0] wr_b_pipe_d [L];

  logic [2:0] shift;
  logic [8:0] k_scaled;
  logic [8:0] tw_off;
  logic [8:0] tw_full;

  // Sequencer next-state: layer/k/drain counters and latched mode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    layer_d = layer_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          k_d     = '0;
          layer_d = '0;
          mode_d  = mode_i;
        end
      end
      S_READ: begin
        if (k_q == K_W'(N_RD - 1)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_W'(L - 1)) begin
          if (layer_q == 3'(N_LAYERS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            layer_d = layer_q + 3'd1;
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + D_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state
  always_comb begin
    rd_en_d     = (state_d == S_READ);
    busy_d      = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    // log2(len): NTT starts at 7 and shrinks, iNTT starts at 1 and grows
    shift       = mode_d ? (layer_d + 3'd1) : (3'd7 - layer_d);
    k_scaled    = 9'(k_d) << 3;
    tw_off      = k_scaled >> shift;
    if (mode_d) tw_full = (9'd256 >> shift) - 9'd1 - tw_off;
    else        tw_full = (9'd128 >> shift) + tw_off;
    len_d       = busy_d ? (8'd1 << shift) : 8'd0;
    layer_o_d   = busy_d ? layer_d : 3'd0;
    rd_addr_a_d = rd_en_d ? ADDR_WIDTH'(k_d) : '0;
    rd_addr_b_d = rd_en_d ? (ADDR_WIDTH'(k_d) + ADDR_WIDTH'(N_RD)) : '0;
    tw_idx_d    = rd_en_d ? 7'(tw_full) : 7'd0;
  end

  // Write-back delay line: read strobe/addresses shifted by L cycles
  always_comb begin
    wr_en_pipe_d    = wr_en_pipe_q;
    wr_a_pipe_d     = wr_a_pipe_q;
    wr_b_pipe_d     = wr_b_pipe_q;
    wr_en_pipe_d[0] = rd_en_q;
    wr_a_pipe_d[0]  = rd_addr_a_q;
    wr_b_pipe_d[0]  = rd_addr_b_q;
    for (int i = 1; i < int'(L); i++) begin
      wr_en_pipe_d[i] = wr_en_pipe_q[i-1];
      wr_a_pipe_d[i]  = wr_a_pipe_q[i-1];
      wr_b_pipe_d[i]  = wr_b_pipe_q[i-1];
    end
  end

  // State, output and pipeline registers; reset also flushes pending writes
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      dcnt_q       <= '0;
      layer_q      <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= '0;
      layer_o_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_a_q  <= '0;
      rd_addr_b_q  <= '0;
      tw_idx_q     <= '0;
      wr_en_pipe_q <= '0;
      for (int i = 0; i < int'(L); i++) begin
        wr_a_pipe_q[i] <= '0;
        wr_b_pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      dcnt_q       <= dcnt_d;
      layer_q      <= layer_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      len_q        <= len_d;
      layer_o_q    <= layer_o_d;
      rd_en_q      <= rd_en_d;
      rd_addr_a_q  <= rd_addr_a_d;
      rd_addr_b_q  <= rd_addr_b_d;
      tw_idx_q     <= tw_idx_d;
      wr_en_pipe_q <= wr_en_pipe_d;
      wr_a_pipe_q  <= wr_a_pipe_d;
      wr_b_pipe_q  <= wr_b_pipe_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign len_o       = len_q;
  assign layer_o     = layer_o_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign tw_idx_o    = tw_idx_q;
  assign wr_en_o     = wr_en_pipe_q[L-1];
  assign wr_addr_a_o = wr_a_pipe_q[L-1];
  assign wr_addr_b_o = wr_b_pipe_q[L-1];

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Self-checking bench for ntt_layer_ctrl: per-cycle comparison of every output
// against a cycle-position model, with random start/mode noise during runs.
module tb_ntt_layer_ctrl;

  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          mode_i;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    len_o;
  logic [2:0]    layer_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_a_o;
  logic [AW-1:0] rd_addr_b_o;
  logic [6:0]    tw_idx_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_a_o;
  logic [AW-1:0] wr_addr_b_o;

  int n_tests = 0;
  int n_fail  = 0;

  ntt_layer_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .len_o       (len_o),
    .layer_o     (layer_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .tw_idx_o    (tw_idx_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare all outputs against a full expected vector
  task automatic chk_all(input string tag, input int busy, input int done, input int len,
                         input int lyr, input int rd, input int ra, input int rb, input int tw,
                         input int wr, input int wa, input int wb);
    chk({tag, ".busy"}, 32'(busy_o), 32'(busy));
    chk({tag, ".done"}, 32'(done_o), 32'(done));
    chk({tag, ".len"}, 32'(len_o), 32'(len));
    chk({tag, ".layer"}, 32'(layer_o), 32'(lyr));
    chk({tag, ".rd_en"}, 32'(rd_en_o), 32'(rd));
    chk({tag, ".rd_a"}, 32'(rd_addr_a_o), 32'(ra));
    chk({tag, ".rd_b"}, 32'(rd_addr_b_o), 32'(rb));
    chk({tag, ".tw"}, 32'(tw_idx_o), 32'(tw));
    chk({tag, ".wr_en"}, 32'(wr_en_o), 32'(wr));
    chk({tag, ".wr_a"}, 32'(wr_addr_a_o), 32'(wa));
    chk({tag, ".wr_b"}, 32'(wr_addr_b_o), 32'(wb));
  endtask

  task automatic chk_idle(input string tag);
    chk_all(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference: cycle c (1..148) after the start edge; 21 cycles per layer,
  // reads at positions 0..15, write-backs at positions 5..20, done at 148.
  task automatic chk_cycle(input bit m, input int c);
    string tag;
    int lyr, pos, len, k, tw, w;
    tag = $sformatf("%s_c%0d", m ? "intt" : "ntt", c);
    if (c == 148) begin
      chk_all(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end else begin
      lyr = (c - 1) / 21;
      pos = (c - 1) % 21;
      len = m ? (2 << lyr) : (128 >> lyr);
      k   = pos;
      w   = pos - 5;
      if (pos < 16) begin
        tw = m ? (256 / len - 1 - (8 * k) / len) : (128 / len + (8 * k) / len);
        if (pos >= 5)
          chk_all(tag, 1, 0, len, lyr, 1, k, k + 16, tw, 1, w, w + 16);
        else
          chk_all(tag, 1, 0, len, lyr, 1, k, k + 16, tw, 0, 0, 0);
      end else begin
        chk_all(tag, 1, 0, len, lyr, 0, 0, 0, 0, 1, w, w + 16);
      end
    end
  endtask

  // One run from IDLE; abort_at > 0 stops after checking that cycle.
  // start_i is left high in the DONE cycle to confirm it is ignored there.
  task automatic run(input bit m, input int abort_at);
    start_i = 1'b1;
    mode_i  = m;
    step();
    for (int c = 1; c <= 148; c++) begin
      if (c > 1) step();
      chk_cycle(m, c);
      start_i = 1'($urandom_range(0, 1));
      mode_i  = 1'($urandom_range(0, 1));
      if (c == 39) start_i = 1'b1;
      if (c == 148) start_i = 1'b1;
      if (abort_at != 0 && c == abort_at) begin
        start_i = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b1;
    mode_i  = 1'b0;

    // Reset held with start asserted: nothing may start
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("reset_%0d", i));
    end
    start_i = 1'b0;
    rst_i   = 1'b1;
    step();
    chk_idle("post_reset");

    // Directed NTT then iNTT, then back-to-back iNTT right after done
    run(1'b0, 0);
    step();
    chk_idle("ntt_end");
    start_i = 1'b0;
    step();
    chk_idle("ntt_idle");

    run(1'b1, 0);
    step();
    chk_idle("intt_end");
    run(1'b1, 0);
    step();
    chk_idle("b2b_end");
    start_i = 1'b0;

    // Randomised runs with random idle gaps
    for (int r = 0; r < 4; r++) begin
      run(1'($urandom_range(0, 1)), 0);
      step();
      chk_idle($sformatf("rand%0d_end", r));
      start_i = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        chk_idle($sformatf("rand%0d_gap%0d", r, g));
      end
    end

    // Reset during layer 1 READ, then a clean full run
    run(1'b0, 29);
    rst_i = 1'b0;
    step();
    chk_idle("midrst");
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle($sformatf("midrst_after%0d", i));
    end
    run(1'b0, 0);
    step();
    chk_idle("midrst_rerun_end");
    start_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_layer_ctrl.md
Name: ntt_layer_ctrl

Overview:
Layer sequencer for the 8-butterfly NTT/iNTT datapath (256 coefficients, 12-bit, q=3329).
- Walks all 7 layers in NTT order (len 128->2) or iNTT order (len 2->128).
- Per layer, issues 16 bank-read cycles and drives len to the BU routing crossbar.
- Emits the per-cycle twiddle base index and delays write-back strobes/addresses by the read+BU pipeline latency.
- Stalls between layers until all write-backs of the current layer have landed.

Parameters:
ADDR_WIDTH, 5, bank word address width (32 words per bank)
RD_LAT, 1, BRAM read latency in cycles
BU_LAT, 4, butterfly unit latency in cycles
N_RD, 16, read cycles per layer (128 butterflies / 8 BUs)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
start_i  in  1  start request, sampled only in IDLE
mode_i  in  1  0 = NTT, 1 = iNTT; latched on accepted start
busy_o  out  1  high from the cycle after start acceptance through the last DRAIN cycle
done_o  out  1  one-cycle pulse after the final write-back
len_o  out  8  current layer length to the crossbar; held through READ and DRAIN
layer_o  out  3  layer index 0..6
rd_en_o  out  1  bank read strobe
rd_addr_a_o  out  ADDR_WIDTH  port A read address = k
rd_addr_b_o  out  ADDR_WIDTH  port B read address = k + 16
tw_idx_o  out  7  twiddle base index for BU0; BU j adds j/len (NTT) or subtracts it (iNTT)
wr_en_o  out  1  write-back strobe, rd_en_o delayed by L = RD_LAT + BU_LAT
wr_addr_a_o  out  ADDR_WIDTH  rd_addr_a_o delayed by L
wr_addr_b_o  out  ADDR_WIDTH  rd_addr_b_o delayed by L

Behaviour:
- Reset (rst_i=0 at an edge):
  - State returns to IDLE.
  - All outputs are 0, including len_o.
  - The delay pipeline is flushed, so pending writes are discarded.
  - Reset takes effect mid-run with no further wr_en_o.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start_i=1, latch mode_i, set layer=0, k=0, and go to READ.
  - First layer len = 128 (NTT) or 2 (iNTT).
- READ:
  - rd_en_o=1, rd_addr_a_o=k, rd_addr_b_o=k+16.
  - k increments 0..15; after k=15, go to DRAIN.
- DRAIN:
  - Lasts exactly L cycles with rd_en_o=0.
  - Then: if layer=6, go to DONE. Otherwise layer+1, k=0, go to READ.
  - len update: NTT len>>=1, iNTT len<<=1.
- DONE:
  - done_o=1 and busy_o=0 for one cycle, then go to IDLE.
  - start_i sampled in DONE is ignored.
- start_i is ignored while busy. mode_i changes mid-run have no effect.
- Twiddle index (7-bit, never wraps for legal values):
  - NTT: tw_idx_o = 128/len + (8k)/len.
  - iNTT: tw_idx_o = 256/len - 1 - (8k)/len.
  - Division by len is a right shift by log2(len), computed from layer.
- Write pipeline:
  - wr_* are exact L-cycle delayed copies of rd_en/rd_addr.
  - The last write of a layer occurs in the final DRAIN cycle, so the next layer's first read never precedes a pending write (no RAW hazard).
- Timing:
  - Each layer is N_RD + L = 21 cycles.
  - With start sampled at edge 0: first rd_en_o is high in cycle 1; done_o is high in cycle 1 + 7*21 = 148.
- tw_idx_o and rd_addr_* are 0 whenever rd_en_o=0.

Test Plan:
- Reset check: hold rst_i=0 for 3 cycles -> all outputs 0, state IDLE; start_i=1 during reset -> no rd_en_o.
- NTT run: start_i=1, mode_i=0 ->
  - Layer 0: len_o=128, 16 reads with addr_a 0..15 / addr_b 16..31, tw_idx_o=1 throughout.
  - Layer 3 (len 16): tw_idx_o = 8,8,9,9,...,15,15.
  - wr_en_o trails rd_en_o by 5 cycles.
  - done_o pulses at cycle 148.
- iNTT run: mode_i=1 ->
  - len_o sequence 2,4,...,128.
  - Layer 0: tw_idx_o = 127,123,119,...,67.
  - Layer 6 (len 128): tw_idx_o=1.
  - done_o at cycle 148.
- Start while busy: pulse start_i at cycle 40 and again in the DONE cycle -> single run only, one done_o, returns to IDLE.
- Reset mid-run: assert rst_i=0 at cycle 30, during layer 1 READ -> next cycle all outputs 0 and no wr_en_o afterwards; a new start runs a full 148-cycle sequence from layer 0.
- Back-to-back: start_i=1 on the cycle after done_o, mode_i=1 -> accepted from IDLE; iNTT sequence starts with len_o=2.
